// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER unified-memory arbiter.
package otter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_IF,
        GNT_MEM
    } grant_t;

    // funct3[1:0] access sizes
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/otter_arb_fair_cnt.sv
// Saturating fairness counter: counts data grants made while a fetch is
// waiting and raises force_if once MAX_DATA_BURST of them have happened.
module otter_arb_fair_cnt #(
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic in_idle,
    input  logic if_req,
    input  logic if_gnt,
    input  logic mem_gnt,
    output logic force_if
);

    localparam int unsigned CNT_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_BURST);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear on IF grant or on an idle cycle with no fetch; otherwise count
    // data grants that bypassed a waiting fetch, saturating at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (if_gnt || (in_idle && !if_req)) begin
            cnt_d = '0;
        end else if (mem_gnt && if_req && (cnt_q < CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if = (cnt_q >= CNT_MAX);

endmodule

// File: rtl/otter_mem_arbiter.sv
// Arbiter sharing the single-port OTTER memory between instruction fetch and
// the MEM-stage data port. Data has priority, bounded by a fairness counter.
// Optional performance counters are enabled with OTTER_ARB_PERF_EN.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [1:0]        mem_size,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [1:0]        ram_size,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall_if,
    output logic              stall_mem
`ifdef OTTER_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_stall_cnt,
    output logic [31:0]       perf_mem_stall_cnt,
    output logic [31:0]       perf_forced_if_cnt
`endif
);

    arb_state_t        state_q, state_d;
    grant_t            gnt_q, gnt_d, gnt_sel;
    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [1:0]        ram_size_q, ram_size_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              mem_valid_q, mem_valid_d;

    logic in_idle, any_req, if_gnt, mem_gnt, force_if;

    assign in_idle = (state_q == IDLE);
    assign any_req = if_req | mem_req;
    assign gnt_sel = (mem_req && !(if_req && force_if)) ? GNT_MEM : GNT_IF;
    assign if_gnt  = in_idle && any_req && (gnt_sel == GNT_IF);
    assign mem_gnt = in_idle && any_req && (gnt_sel == GNT_MEM);

    otter_arb_fair_cnt #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_fair_cnt (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .in_idle (in_idle),
        .if_req  (if_req),
        .if_gnt  (if_gnt),
        .mem_gnt (mem_gnt),
        .force_if(force_if)
    );

    // Next-state and registered-output logic for the IDLE/ISSUE/RESP sequence.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_size_d  = ram_size_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d     = gnt_sel;
                    ram_req_d = 1'b1;
                    state_d   = ISSUE;
                    if (gnt_sel == GNT_MEM) begin
                        ram_we_d    = mem_we;
                        ram_addr_d  = mem_addr;
                        ram_wdata_d = mem_wdata;
                        ram_size_d  = mem_size;
                    end else begin
                        ram_we_d    = 1'b0;
                        ram_addr_d  = if_addr;
                        ram_wdata_d = '0;
                        ram_size_d  = SZ_WORD;
                    end
                end
            end
            ISSUE: begin
                if (ram_ack) begin
                    ram_req_d = 1'b0;
                    state_d   = RESP;
                    if (gnt_q == GNT_MEM) begin
                        mem_valid_d = 1'b1;
                        // Store acks carry no meaningful data; keep last load value.
                        if (!ram_we_q) begin
                            mem_rdata_d = ram_rdata;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_size_q  <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_size_q  <= ram_size_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_size  = ram_size_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_valid  = if_valid_q;
    assign mem_valid = mem_valid_q;

    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = mem_req & ~mem_valid_q;

`ifdef OTTER_ARB_PERF_EN
    logic [31:0] perf_if_stall_q, perf_mem_stall_q, perf_forced_if_q;
    logic        forced_if;

    // An IF grant while data was also requesting can only come from the fairness rule.
    assign forced_if = if_gnt & mem_req;

    // Free-running wrap-around event counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perf_if_stall_q  <= '0;
            perf_mem_stall_q <= '0;
            perf_forced_if_q <= '0;
        end else begin
            if (stall_if)  perf_if_stall_q  <= perf_if_stall_q + 32'd1;
            if (stall_mem) perf_mem_stall_q <= perf_mem_stall_q + 32'd1;
            if (forced_if) perf_forced_if_q <= perf_forced_if_q + 32'd1;
        end
    end

    assign perf_if_stall_cnt  = perf_if_stall_q;
    assign perf_mem_stall_cnt = perf_mem_stall_q;
    assign perf_forced_if_cnt = perf_forced_if_q;
`endif

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Self-checking bench for otter_mem_arbiter with a behavioural memory responder
// and a transaction-level grant/fairness model.
module tb_otter_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int          MAXB   = 4;

    logic              CLK, RST_N;
    logic              if_req, if_valid, mem_req, mem_we, mem_valid;
    logic [ADDR_W-1:0] if_addr, mem_addr, ram_addr;
    logic [DATA_W-1:0] if_rdata, mem_wdata, mem_rdata, ram_wdata, ram_rdata;
    logic [1:0]        mem_size, ram_size;
    logic              ram_req, ram_we, ram_ack, stall_if, stall_mem;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } acc_t;

    acc_t        log_q[$];
    int          ack_delay  = 0;
    bit          rand_delay = 0;
    bit          fixed_en   = 0;
    logic [31:0] fixed_val  = '0;
    logic [31:0] last_if    = '0;
    logic [31:0] last_mem   = '0;

`ifdef OTTER_ARB_PERF_EN
    logic [31:0] perf_if_stall_cnt, perf_mem_stall_cnt, perf_forced_if_cnt;
    int unsigned tb_if_stall  = 0;
    int unsigned tb_mem_stall = 0;
    always @(posedge CLK) begin
        if (RST_N && stall_if)  tb_if_stall  <= tb_if_stall + 1;
        if (RST_N && stall_mem) tb_mem_stall <= tb_mem_stall + 1;
    end
`endif

    otter_mem_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .MAX_DATA_BURST(MAXB)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_size (mem_size),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
        .ram_req  (ram_req),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_size (ram_size),
        .ram_ack  (ram_ack),
        .ram_rdata(ram_rdata),
        .stall_if (stall_if),
        .stall_mem(stall_mem)
`ifdef OTTER_ARB_PERF_EN
        ,
        .perf_if_stall_cnt (perf_if_stall_cnt),
        .perf_mem_stall_cnt(perf_mem_stall_cnt),
        .perf_forced_if_cnt(perf_forced_if_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    // Memory model: acks after a programmable number of request cycles.
    initial begin : responder
        int   wcnt;
        int   cur;
        bit   active;
        acc_t a;
        wcnt = 0; cur = 0; active = 0;
        ram_ack = 1'b0; ram_rdata = '0;
        forever begin
            @(negedge CLK);
            ram_ack = 1'b0;
            if (ram_req && RST_N) begin
                if (!active) begin
                    active = 1;
                    wcnt   = 0;
                    cur    = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
                end
                if (wcnt == cur) begin
                    ram_ack   = 1'b1;
                    ram_rdata = fixed_en ? fixed_val : rdata_of(ram_addr);
                    a.we = ram_we; a.addr = ram_addr; a.wdata = ram_wdata; a.size = ram_size;
                    log_q.push_back(a);
                    active = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                active = 0;
            end
        end
    end

    task automatic test_reset();
        logic [31:0] obs[13];
        string       nm[13];
        repeat (2) @(negedge CLK);
        obs[0] = 32'(ram_req);   nm[0] = "rst_ram_req";
        obs[1] = 32'(ram_we);    nm[1] = "rst_ram_we";
        obs[2] = ram_addr;       nm[2] = "rst_ram_addr";
        obs[3] = ram_wdata;      nm[3] = "rst_ram_wdata";
        obs[4] = 32'(ram_size);  nm[4] = "rst_ram_size";
        obs[5] = if_rdata;       nm[5] = "rst_if_rdata";
        obs[6] = mem_rdata;      nm[6] = "rst_mem_rdata";
        obs[7] = 32'(if_valid);  nm[7] = "rst_if_valid";
        obs[8] = 32'(mem_valid); nm[8] = "rst_mem_valid";
        obs[9] = 32'(stall_if);  nm[9] = "rst_stall_if";
        obs[10] = 32'(stall_mem); nm[10] = "rst_stall_mem";
        RST_N = 1'b1;
        @(negedge CLK);
        obs[11] = 32'(ram_req);  nm[11] = "post_rst_ram_req";
        obs[12] = 32'(if_valid | mem_valid); nm[12] = "post_rst_valid";
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (obs[i] !== 32'h0) begin
                errors++;
                $display("FAIL %s: got %h expected 0", nm[i], obs[i]);
            end
        end
    endtask

    task automatic test_if_fetch();
        fixed_en = 1; fixed_val = 32'h0000_0013; ack_delay = 0;
        if_addr = 32'h100; if_req = 1'b1;
        @(negedge CLK);
        checks++;
        if ({ram_req, ram_we, ram_addr, ram_size} !== {1'b1, 1'b0, 32'h100, 2'b10}) begin
            errors++;
            $display("FAIL fetch_issue: got req=%b we=%b addr=%h size=%b expected 1 0 00000100 10",
                     ram_req, ram_we, ram_addr, ram_size);
        end
        checks++;
        if ({if_valid, stall_if} !== 2'b01) begin
            errors++;
            $display("FAIL fetch_stall: got valid=%b stall=%b expected 0 1", if_valid, stall_if);
        end
        @(negedge CLK);
        checks++;
        if ({ram_req, if_valid, mem_valid, stall_if} !== 4'b0100) begin
            errors++;
            $display("FAIL fetch_resp: got req=%b ifv=%b memv=%b stall=%b expected 0 1 0 0",
                     ram_req, if_valid, mem_valid, stall_if);
        end
        checks++;
        if (if_rdata !== 32'h13) begin
            errors++;
            $display("FAIL fetch_rdata: got %h expected 00000013", if_rdata);
        end
        if_req = 1'b0;
        last_if = 32'h13;
        @(negedge CLK);
        checks++;
        if ({ram_req, if_valid, stall_if} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_after: got req=%b ifv=%b stall=%b expected 0 0 0",
                     ram_req, if_valid, stall_if);
        end
        fixed_en = 0;
        log_q.delete();
    endtask

    task automatic test_priority();
        int mem_at, if_at;
        mem_at = -1; if_at = -1;
        ack_delay = 0;
        if_addr = 32'h300; if_req = 1'b1;
        mem_addr = 32'h2000; mem_we = 1'b0; mem_size = 2'b10; mem_wdata = '0; mem_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (mem_valid) begin
                mem_at = c; mem_req = 1'b0;
                checks++;
                if (mem_rdata !== rdata_of(32'h2000)) begin
                    errors++;
                    $display("FAIL prio_mem_rdata: got %h expected %h", mem_rdata, rdata_of(32'h2000));
                end
            end
            if (if_valid) begin
                if_at = c; if_req = 1'b0;
                checks++;
                if (if_rdata !== rdata_of(32'h300)) begin
                    errors++;
                    $display("FAIL prio_if_rdata: got %h expected %h", if_rdata, rdata_of(32'h300));
                end
            end
        end
        checks++;
        if (!(mem_at >= 0 && if_at > mem_at)) begin
            errors++;
            $display("FAIL prio_order: got mem_valid@%0d if_valid@%0d expected mem first", mem_at, if_at);
        end
        checks++;
        if (log_q.size() != 2 || log_q[0].addr !== 32'h2000 || log_q[1].addr !== 32'h300) begin
            errors++;
            $display("FAIL prio_addr_seq: got %0d accesses expected 2 (00002000 then 00000300)",
                     log_q.size());
        end
        last_if = rdata_of(32'h300); last_mem = rdata_of(32'h2000);
        log_q.delete();
    endtask

    task automatic test_fairness();
        bit pred_mem[6];
        int cnt;
        bit got;
`ifdef OTTER_ARB_PERF_EN
        logic [31:0] f0, is0, ms0;
        int unsigned tis0, tms0;
        f0 = perf_forced_if_cnt; is0 = perf_if_stall_cnt; ms0 = perf_mem_stall_cnt;
        tis0 = tb_if_stall; tms0 = tb_mem_stall;
`endif
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            pred_mem[i] = (cnt < MAXB);
            if (pred_mem[i]) cnt = (cnt < MAXB) ? cnt + 1 : cnt;
            else cnt = 0;
        end
        ack_delay = 0;
        if_addr = 32'h500; if_req = 1'b1;
        mem_addr = 32'h4000; mem_we = 1'b0; mem_size = 2'b10; mem_req = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge CLK);
            if (log_q.size() >= 6) got = 1;
        end
        if_req = 1'b0; mem_req = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL fair_timeout: got %0d accesses expected 6", log_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (log_q[i].addr !== (pred_mem[i] ? 32'h4000 : 32'h500)) begin
                    errors++;
                    $display("FAIL fair_grant%0d: got addr %h expected %h", i, log_q[i].addr,
                             pred_mem[i] ? 32'h4000 : 32'h500);
                end
            end
        end
        checks++;
        if (if_rdata !== rdata_of(32'h500) || mem_rdata !== rdata_of(32'h4000)) begin
            errors++;
            $display("FAIL fair_rdata: got if=%h mem=%h expected if=%h mem=%h", if_rdata, mem_rdata,
                     rdata_of(32'h500), rdata_of(32'h4000));
        end
`ifdef OTTER_ARB_PERF_EN
        checks++;
        if (perf_forced_if_cnt - f0 !== 32'd1) begin
            errors++;
            $display("FAIL perf_forced: got %0d expected 1", perf_forced_if_cnt - f0);
        end
        checks++;
        if (perf_if_stall_cnt - is0 !== 32'(tb_if_stall - tis0) ||
            perf_mem_stall_cnt - ms0 !== 32'(tb_mem_stall - tms0)) begin
            errors++;
            $display("FAIL perf_stall: got if=%0d mem=%0d expected if=%0d mem=%0d",
                     perf_if_stall_cnt - is0, perf_mem_stall_cnt - ms0,
                     tb_if_stall - tis0, tb_mem_stall - tms0);
        end
`endif
        last_if = rdata_of(32'h500); last_mem = rdata_of(32'h4000);
        log_q.delete();
    endtask

    task automatic test_store_delay();
        int issue_cyc, valid_cyc;
        issue_cyc = 0; valid_cyc = 0;
        ack_delay = 5;
        mem_we = 1'b1; mem_addr = 32'h3004; mem_wdata = 32'hDEADBEEF; mem_size = 2'b00;
        mem_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (ram_req) begin
                issue_cyc++;
                checks++;
                if ({ram_we, ram_addr, ram_wdata, ram_size} !== {1'b1, 32'h3004, 32'hDEADBEEF, 2'b00}) begin
                    errors++;
                    $display("FAIL store_stable: got we=%b addr=%h wdata=%h size=%b expected 1 00003004 deadbeef 00",
                             ram_we, ram_addr, ram_wdata, ram_size);
                end
            end
            if (mem_valid) begin
                valid_cyc++;
                mem_req = 1'b0;
                checks++;
                if (mem_rdata !== last_mem) begin
                    errors++;
                    $display("FAIL store_rdata: got %h expected %h", mem_rdata, last_mem);
                end
            end
        end
        checks++;
        if (issue_cyc != 6 || valid_cyc != 1) begin
            errors++;
            $display("FAIL store_timing: got issue=%0d valid=%0d expected 6 1", issue_cyc, valid_cyc);
        end
        ack_delay = 0;
        log_q.delete();
    endtask

    task automatic test_reset_mid();
        bit seen;
        ack_delay = 100;
        mem_we = 1'b0; mem_addr = 32'h6000; mem_size = 2'b10; mem_req = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (ram_req !== 1'b1) begin
            errors++;
            $display("FAIL rmid_issue: got ram_req=%b expected 1", ram_req);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({ram_req, ram_addr, mem_valid} !== {1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL rmid_async: got req=%b addr=%h memv=%b expected 0 00000000 0",
                     ram_req, ram_addr, mem_valid);
        end
        @(negedge CLK);
        mem_req = 1'b0;
        RST_N = 1'b1;
        ack_delay = 0;
        seen = 0;
        repeat (3) begin
            @(negedge CLK);
            if (ram_req || if_valid || mem_valid) seen = 1;
        end
        checks++;
        if (seen || if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rmid_quiet: got activity=%b if_rdata=%h mem_rdata=%h expected 0 0 0",
                     seen, if_rdata, mem_rdata);
        end
        if_addr = 32'h700; if_req = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge CLK);
            if (if_valid) seen = 1;
        end
        if_req = 1'b0;
        checks++;
        if (!seen || if_rdata !== rdata_of(32'h700)) begin
            errors++;
            $display("FAIL rmid_resume: got valid=%b rdata=%h expected 1 %h", seen, if_rdata,
                     rdata_of(32'h700));
        end
        @(negedge CLK);
        last_if = rdata_of(32'h700); last_mem = '0;
        log_q.delete();
    endtask

    task automatic test_random();
        bit          if_p, mem_p, exp_mem, done, mwe;
        logic [31:0] ia, ma, mw, exp_if_rd, exp_mem_rd;
        logic [1:0]  msz;
        int          cnt_m;
        acc_t        a;
        cnt_m = 0; rand_delay = 1;
        if_p = 0; mem_p = 0; ia = '0; ma = '0; mw = '0; mwe = 0; msz = 2'b10;
        exp_if_rd = last_if; exp_mem_rd = last_mem;
        log_q.delete();
        for (int t = 0; t < 40; t++) begin
            if (!if_p && $urandom_range(0, 1) == 1) begin
                if_p = 1; ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!mem_p && $urandom_range(0, 1) == 1) begin
                mem_p = 1; ma = $urandom; mw = $urandom;
                mwe = 1'($urandom_range(0, 1)); msz = 2'($urandom_range(0, 2));
            end
            if (!if_p && !mem_p) begin
                if_p = 1; ia = $urandom & 32'hFFFF_FFFC;
            end
            if_req = if_p; if_addr = ia;
            mem_req = mem_p; mem_we = mwe; mem_addr = ma; mem_wdata = mw; mem_size = msz;
            // Data wins unless a waiting fetch has been bypassed MAXB times in a row.
            exp_mem = mem_p && !(if_p && cnt_m >= MAXB);
            if (exp_mem && if_p) cnt_m = (cnt_m < MAXB) ? cnt_m + 1 : cnt_m;
            else cnt_m = 0;
            done = 0;
            for (int c = 0; c < 20 && !done; c++) begin
                @(negedge CLK);
                if (if_valid || mem_valid) done = 1;
            end
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL rand_timeout: txn %0d got no valid expected one within 20 cycles", t);
                break;
            end
            if (exp_mem && !mwe) exp_mem_rd = rdata_of(ma);
            if (!exp_mem) exp_if_rd = rdata_of(ia);
            checks++;
            if ({mem_valid, if_valid} !== {exp_mem, !exp_mem}) begin
                errors++;
                $display("FAIL rand_winner: txn %0d got memv=%b ifv=%b expected %b %b", t,
                         mem_valid, if_valid, exp_mem, !exp_mem);
            end
            checks++;
            if (if_rdata !== exp_if_rd || mem_rdata !== exp_mem_rd) begin
                errors++;
                $display("FAIL rand_rdata: txn %0d got if=%h mem=%h expected if=%h mem=%h", t,
                         if_rdata, mem_rdata, exp_if_rd, exp_mem_rd);
            end
            checks++;
            if ({stall_if, stall_mem} !== {if_p && exp_mem, mem_p && !exp_mem}) begin
                errors++;
                $display("FAIL rand_stall: txn %0d got if=%b mem=%b expected %b %b", t, stall_if,
                         stall_mem, if_p && exp_mem, mem_p && !exp_mem);
            end
            checks++;
            if (log_q.size() != 1) begin
                errors++;
                $display("FAIL rand_access_cnt: txn %0d got %0d expected 1", t, log_q.size());
                log_q.delete();
            end else begin
                a = log_q.pop_front();
                if (exp_mem ? (a.we !== mwe || a.addr !== ma || a.size !== msz ||
                               (mwe && a.wdata !== mw))
                            : (a.we !== 1'b0 || a.addr !== ia || a.size !== 2'b10)) begin
                    errors++;
                    $display("FAIL rand_access: txn %0d got we=%b addr=%h size=%b wdata=%h", t,
                             a.we, a.addr, a.size, a.wdata);
                end
            end
            if (exp_mem) mem_p = 0;
            else if_p = 0;
        end
        if_req = 1'b0; mem_req = 1'b0;
        repeat (4) @(negedge CLK);
        rand_delay = 0;
        last_if = exp_if_rd; last_mem = exp_mem_rd;
        log_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_size = 2'b00;
        test_reset();
        test_if_fetch();
        test_priority();
        test_fairness();
        test_store_delay();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
